pe_nic_fifo: RTL and testbench
==============================

PE_NIC_FIFO -- requirements
Module: pe_nic_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per direction; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pesi  input  1  PE send request (inject).
REQ-006 SHALL have port pero  output  1  ready to PE; inject FIFO not full.
REQ-007 SHALL have port pedi  input  DATA_WIDTH  PE inject data.
REQ-008 SHALL have port netso  output  1  send to router; inject FIFO not empty.
REQ-009 SHALL have port netri  input  1  router ready.
REQ-010 SHALL have port netdo  output  DATA_WIDTH  inject FIFO head.
REQ-011 SHALL have port netsi  input  1  router send (eject).
REQ-012 SHALL have port netro  output  1  ready to router; eject FIFO not full.
REQ-013 SHALL have port netdi  input  DATA_WIDTH  router eject data.
REQ-014 SHALL have port peso  output  1  send to PE; eject FIFO not empty.
REQ-015 SHALL have port peri  input  1  PE ready.
REQ-016 SHALL have port pedo  output  DATA_WIDTH  eject FIFO head.
REQ-017 SHALL have ports inj_cnt, ej_cnt  output  log2(DEPTH)+1  occupancy (NIC_STATUS_EN only).

Function
REQ-018 SHALL contain two independent FIFOs: inject (pedi->netdo) and eject (netdi->pedo), each DEPTH x DATA_WIDTH.
REQ-019 SHALL write inject FIFO on edge where pesi && pero; read on edge where netso && netri.
REQ-020 SHALL write eject FIFO on edge where netsi && netro; read on edge where peso && peri.
REQ-021 SHALL drive pero/netro = !full and netso/peso = !empty, all from registered occupancy (no combinational path from any input to any output).
REQ-022 SHALL present head data combinationally from storage; data written at edge N visible on netdo/pedo, valid asserted, after edge N (latency 1).
REQ-023 SHALL preserve FIFO order; no drop, duplication or reorder.
REQ-024 SHALL use wrapping pointers of width log2(DEPTH) plus occupancy counter 0..DEPTH.
REQ-025 Full + simultaneous read: write SHALL remain blocked that cycle (ready low); count decrements by 1.
REQ-026 Empty + write: read SHALL NOT occur that cycle; count becomes 1.
REQ-027 Simultaneous read and write when neither full nor empty: count SHALL be unchanged, both pointers advance.
REQ-028 pesi while pero low SHALL be ignored; pedi unsampled.
REQ-029 netdo/pedo SHALL be don't-care while corresponding send signal is low.

Reset
REQ-030 reset SHALL asynchronously clear pointers and counters: pero=1, netro=1, netso=0, peso=0, inj_cnt=0, ej_cnt=0.
REQ-031 Storage contents SHALL NOT require reset; reset mid-transfer SHALL discard all queued packets.
REQ-032 First transfer SHALL be accepted on first rising edge after reset deassertion.

Configuration
REQ-033 Macro NIC_STATUS_EN defined: inj_cnt/ej_cnt ports exist and equal live occupancy; sticky overflow-attempt flag ovf (output 1) sets when pesi && !pero or netsi && !netro, cleared only by reset.
REQ-034 Macro NIC_STATUS_EN undefined: inj_cnt, ej_cnt, ovf ports absent; datapath behaviour identical.

Verification
REQ-035 Reset, then pesi=1 with pedi=0xA0..0xA3 over 4 cycles, netri=0 -> pero low after 4th edge, netso=1, netdo=0xA0.
REQ-036 From REQ-035 state, netri=1 for 4 cycles, pesi=0 -> netdo sequence 0xA0,0xA1,0xA2,0xA3; then netso=0, pero=1.
REQ-037 Full inject FIFO, pesi=1 pedi=0xFF and netri=1 same cycle -> 0xFF not accepted, count 3, pero=1 next cycle (ovf=1 if NIC_STATUS_EN).
REQ-038 Eject FIFO count 2, netsi=1 and peri=1 continuously with data 0x10,0x11,... -> ej_cnt stays 2, pedo strictly ordered.
REQ-039 reset asserted mid-burst with 3 entries queued in each FIFO -> immediately netso=0, peso=0, pero=1, netro=1, counts 0.
REQ-040 DATA_WIDTH=32, DEPTH=8: 8 writes fill, 9th blocked; drain returns all 8 in order.

Source files
------------

// File: rtl/pe_nic_fifo.sv
// PE <-> router network interface: independent inject and eject FIFOs.
// Optional NIC_STATUS_EN adds inj_cnt/ej_cnt occupancy and sticky ovf.
module pe_nic_fifo_q #(
  parameter int W = 64,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [W-1:0]           wdata,
  input  logic                   rd,
  output logic [W-1:0]           rdata,
  output logic [$clog2(D):0]     cnt
);

  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULLV = CW'(D);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          full;
  logic          empty;
  logic          we;
  logic          re;

  assign full  = (cnt == FULLV);
  assign empty = (cnt == '0);
  assign we    = wr && !full;
  assign re    = rd && !empty;
  assign rdata = mem[rp];

  // storage: written only on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (we) mem[wp] <= wdata;
  end

  // pointers wrap naturally since D is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
    end
  end

  // occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({we, re})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

module pe_nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pesi,
  output logic                    pero,
  input  logic [DATA_WIDTH-1:0]   pedi,
  output logic                    netso,
  input  logic                    netri,
  output logic [DATA_WIDTH-1:0]   netdo,
  input  logic                    netsi,
  output logic                    netro,
  input  logic [DATA_WIDTH-1:0]   netdi,
  output logic                    peso,
  input  logic                    peri,
`ifdef NIC_STATUS_EN
  output logic [$clog2(DEPTH):0]  inj_cnt,
  output logic [$clog2(DEPTH):0]  ej_cnt,
  output logic                    ovf,
`endif
  output logic [DATA_WIDTH-1:0]   pedo
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  logic [CW-1:0] ic;
  logic [CW-1:0] ec;

  pe_nic_fifo_q #(
    .W (DATA_WIDTH),
    .D (DEPTH)
  ) u_inj (
    .clk   (clk),
    .reset (reset),
    .wr    (pesi),
    .wdata (pedi),
    .rd    (netri),
    .rdata (netdo),
    .cnt   (ic)
  );

  pe_nic_fifo_q #(
    .W (DATA_WIDTH),
    .D (DEPTH)
  ) u_ej (
    .clk   (clk),
    .reset (reset),
    .wr    (netsi),
    .wdata (netdi),
    .rd    (peri),
    .rdata (pedo),
    .cnt   (ec)
  );

  // handshake flags decode only registered occupancy
  assign pero  = (ic != FULLV);
  assign netso = (ic != '0);
  assign netro = (ec != FULLV);
  assign peso  = (ec != '0);

`ifdef NIC_STATUS_EN
  assign inj_cnt = ic;
  assign ej_cnt  = ec;

  // sticky flag for any push offered while the target FIFO is full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if ((pesi && !pero) || (netsi && !netro)) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_nic_fifo.sv
// Self-checking bench for pe_nic_fifo: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pe_nic_fifo;

  localparam int DW = 64;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          pesi, pero, netso, netri, netsi, netro, peso, peri;
  logic [DW-1:0] pedi, netdo, netdi, pedo;
`ifdef NIC_STATUS_EN
  logic [2:0]    inj_cnt, ej_cnt;
  logic          ovf;
`endif

  logic          b_pesi, b_pero, b_netso, b_netri;
  logic          b_netsi, b_netro, b_peso, b_peri;
  logic [31:0]   b_pedi, b_netdo, b_netdi, b_pedo;
`ifdef NIC_STATUS_EN
  logic [3:0]    b_inj_cnt, b_ej_cnt;
  logic          b_ovf;
`endif

  pe_nic_fifo #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .pesi    (pesi),
    .pero    (pero),
    .pedi    (pedi),
    .netso   (netso),
    .netri   (netri),
    .netdo   (netdo),
    .netsi   (netsi),
    .netro   (netro),
    .netdi   (netdi),
    .peso    (peso),
    .peri    (peri),
`ifdef NIC_STATUS_EN
    .inj_cnt (inj_cnt),
    .ej_cnt  (ej_cnt),
    .ovf     (ovf),
`endif
    .pedo    (pedo)
  );

  pe_nic_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .pesi    (b_pesi),
    .pero    (b_pero),
    .pedi    (b_pedi),
    .netso   (b_netso),
    .netri   (b_netri),
    .netdo   (b_netdo),
    .netsi   (b_netsi),
    .netro   (b_netro),
    .netdi   (b_netdi),
    .peso    (b_peso),
    .peri    (b_peri),
`ifdef NIC_STATUS_EN
    .inj_cnt (b_inj_cnt),
    .ej_cnt  (b_ej_cnt),
    .ovf     (b_ovf),
`endif
    .pedo    (b_pedo)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pesi = 0; netri = 0; netsi = 0; peri = 0;
    pedi = '0; netdi = '0;
    b_pesi = 0; b_netri = 0; b_netsi = 0; b_peri = 0;
    b_pedi = '0; b_netdi = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("rst_pero", pero, 1);
    chk("rst_netro", netro, 1);
    chk("rst_netso", netso, 0);
    chk("rst_peso", peso, 0);
`ifdef NIC_STATUS_EN
    chk("rst_inj_cnt", inj_cnt, 0);
    chk("rst_ej_cnt", ej_cnt, 0);
    chk("rst_ovf", ovf, 0);
`endif
  endtask

  typedef struct {
    logic       pesi;
    logic [7:0] pedi;
    logic       netri;
    logic       e_pero;
    logic       e_netso;
    logic       chk_data;
    logic [7:0] e_netdo;
  } vec_t;

  vec_t tbl [8];

  logic [DW-1:0] qi [$];
  logic [DW-1:0] qe [$];
  logic          m_ovf;

  initial begin
    reset = 1;
    idle();

    tbl[0] = '{1, 8'hA0, 0, 1, 1, 1, 8'hA0};
    tbl[1] = '{1, 8'hA1, 0, 1, 1, 1, 8'hA0};
    tbl[2] = '{1, 8'hA2, 0, 1, 1, 1, 8'hA0};
    tbl[3] = '{1, 8'hA3, 0, 0, 1, 1, 8'hA0};
    tbl[4] = '{0, 8'h00, 1, 1, 1, 1, 8'hA1};
    tbl[5] = '{0, 8'h00, 1, 1, 1, 1, 8'hA2};
    tbl[6] = '{0, 8'h00, 1, 1, 1, 1, 8'hA3};
    tbl[7] = '{0, 8'h00, 1, 1, 0, 0, 8'h00};

    // fill then drain via vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pesi  = tbl[i].pesi;
      pedi  = DW'(tbl[i].pedi);
      netri = tbl[i].netri;
      tick();
      chk($sformatf("tbl%0d_pero", i), pero, tbl[i].e_pero);
      chk($sformatf("tbl%0d_netso", i), netso, tbl[i].e_netso);
      chk($sformatf("tbl%0d_peso", i), peso, 0);
      if (tbl[i].chk_data)
        chk($sformatf("tbl%0d_netdo", i), netdo,
            64'(tbl[i].e_netdo));
    end
    idle();

    // full inject FIFO with simultaneous pop: push blocked
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pesi = 1;
      pedi = 64'hB0 + 64'(i);
      tick();
    end
    chk("full_pero", pero, 0);
    pedi = 64'hFF;
    netri = 1;
    tick();
    idle();
    chk("fullrd_pero", pero, 1);
    chk("fullrd_netdo", netdo, 64'hB1);
`ifdef NIC_STATUS_EN
    chk("fullrd_cnt", inj_cnt, 3);
    chk("fullrd_ovf", ovf, 1);
`endif
    netri = 1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("fulldrain%0d", i), netdo, 64'hB0 + 64'(i));
      tick();
    end
    chk("fulldrain_netso", netso, 0);
    idle();

    // eject steady state at count 2
    do_reset();
    netsi = 1;
    netdi = 64'h10;
    tick();
    netdi = 64'h11;
    tick();
    chk("ej2_pedo", pedo, 64'h10);
    peri = 1;
    for (int i = 0; i < 6; i++) begin
      netdi = 64'h12 + 64'(i);
      tick();
      chk($sformatf("ejss%0d_pedo", i), pedo, 64'h11 + 64'(i));
      chk($sformatf("ejss%0d_peso", i), peso, 1);
`ifdef NIC_STATUS_EN
      chk($sformatf("ejss%0d_cnt", i), ej_cnt, 2);
`endif
    end
    idle();

    // reset mid-burst, then first transfer right after release
    do_reset();
    pesi = 1;
    netsi = 1;
    for (int i = 0; i < 3; i++) begin
      pedi = 64'hC0 + 64'(i);
      netdi = 64'hD0 + 64'(i);
      tick();
    end
    chk("mid_netso", netso, 1);
    chk("mid_peso", peso, 1);
    reset = 1;
    #1;
    chk("midrst_netso", netso, 0);
    chk("midrst_peso", peso, 0);
    chk("midrst_pero", pero, 1);
    chk("midrst_netro", netro, 1);
`ifdef NIC_STATUS_EN
    chk("midrst_icnt", inj_cnt, 0);
    chk("midrst_ecnt", ej_cnt, 0);
`endif
    idle();
    @(negedge clk);
    reset = 0;
    pesi = 1;
    pedi = 64'hC5;
    tick();
    idle();
    chk("first_netso", netso, 1);
    chk("first_netdo", netdo, 64'hC5);

    // 32-bit, depth 8 instance: fill, block 9th, drain in order
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b_pesi = 1;
      b_pedi = 32'h80 + 32'(i);
      tick();
    end
    b_pesi = 0;
    chk("b_full_pero", b_pero, 0);
`ifdef NIC_STATUS_EN
    chk("b_full_cnt", b_inj_cnt, 8);
`endif
    b_netri = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_drain%0d", i), b_netdo, 32'h80 + 32'(i));
      tick();
    end
    chk("b_empty_netso", b_netso, 0);
    idle();

    // randomized traffic against queue model
    do_reset();
    qi.delete();
    qe.delete();
    m_ovf = 0;
    for (int c = 0; c < 400; c++) begin
      logic wi, ri, we_, re_;
      logic [DW-1:0] di, de;
      chk("rnd_pero", pero, qi.size() < D);
      chk("rnd_netso", netso, qi.size() != 0);
      chk("rnd_netro", netro, qe.size() < D);
      chk("rnd_peso", peso, qe.size() != 0);
      if (qi.size() != 0) chk("rnd_netdo", netdo, qi[0]);
      if (qe.size() != 0) chk("rnd_pedo", pedo, qe[0]);
`ifdef NIC_STATUS_EN
      chk("rnd_icnt", inj_cnt, 64'(qi.size()));
      chk("rnd_ecnt", ej_cnt, 64'(qe.size()));
      chk("rnd_ovf", ovf, m_ovf);
`endif
      pesi  = 1'($urandom_range(0, 1));
      netri = ($urandom_range(0, 3) == 0);
      netsi = ($urandom_range(0, 3) != 0);
      peri  = 1'($urandom_range(0, 1));
      pedi  = {$urandom, $urandom};
      netdi = {$urandom, $urandom};
      di = pedi;
      de = netdi;
      wi  = pesi && qi.size() < D;
      ri  = netri && qi.size() > 0;
      we_ = netsi && qe.size() < D;
      re_ = peri && qe.size() > 0;
      if ((pesi && qi.size() == D) || (netsi && qe.size() == D))
        m_ovf = 1;
      tick();
      if (ri) void'(qi.pop_front());
      if (wi) qi.push_back(di);
      if (re_) void'(qe.pop_front());
      if (we_) qe.push_back(de);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
